// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO offsets, lane helpers.
// Pure definitions; no latency, no flow control.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } size_e;

    localparam logic [31:0] LED_OFS = 32'h0000_0000;
    localparam logic [31:0] CYC_OFS = 32'h0000_0004;

    // One bit per byte lane of the addressed word that a store of this size touches.
    function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] ofs);
        logic [3:0] lanes;
        lanes = 4'b0000;
        case (size)
            SZ_B:    lanes = 4'b0001 << ofs;
            SZ_H:    lanes = ofs[1] ? 4'b1100 : 4'b0011;
            SZ_W:    lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    // Replicates the low byte/half across the word so any selected lane sees its data.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        case (size)
            SZ_B:    d = {4{wdata[7:0]}};
            SZ_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_mmio.sv
// MMIO register file: LED register (R/W) and free-running CYCLE counter with read mux.
// Writes land at the posedge; read data is combinational from current register state; never stalls.
module dmem_mmio
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        led_we,
    input  logic [31:0] wdata,
    input  logic        rd_cyc,
    output logic [31:0] led_o,
    output logic [31:0] rdata
);

    logic [31:0] cycle;

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_o <= 32'h0;
            cycle <= 32'h0;
        end else begin
            cycle <= cycle + 32'h1;
            if (led_we)
                led_o <= wdata;
        end
    end

    assign rdata = rd_cyc ? cycle : led_o;

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory plus MMIO window with byte/half/word access and fault flagging.
// Loads return exactly one cycle later; no backpressure, a request is accepted every cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_we,
    input  logic        dmem_re,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [1:0]  dmem_size,
    output logic [31:0] dmem_rdata,
    output logic        dmem_rvalid,
    output logic        dmem_err,
    output logic [31:0] led_o
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          ram_hit;
    logic          led_hit;
    logic          cyc_hit;
    logic          misalign;
    logic          fault;
    logic          wr_ok;
    logic [3:0]    lanes;
    logic [31:0]   wdat;
    logic [31:0]   mmio_rdata;

    assign idx      = dmem_addr[AW+1:2];
    assign ram_hit  = dmem_addr < RAM_BYTES;
    assign led_hit  = dmem_addr == (MMIO_BASE + LED_OFS);
    assign cyc_hit  = dmem_addr == (MMIO_BASE + CYC_OFS);
    assign misalign = (dmem_size == SZ_H && dmem_addr[0])
                   || (dmem_size == SZ_W && dmem_addr[1:0] != 2'b00)
                   || (dmem_size == SZ_BAD);
    assign fault    = misalign
                   || (!ram_hit && !led_hit && !cyc_hit)
                   || ((led_hit || cyc_hit) && dmem_size != SZ_W)
                   || (dmem_we && dmem_re);
    assign wr_ok    = rst && dmem_we && !fault;
    assign lanes    = byte_lanes(dmem_size, dmem_addr[1:0]);
    assign wdat     = lane_data(dmem_size, dmem_wdata);

    // RAM is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_ok && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i])
                    mem[idx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_rdata  <= 32'h0;
            dmem_rvalid <= 1'b0;
            dmem_err    <= 1'b0;
        end else begin
            dmem_rvalid <= dmem_re;
            dmem_err    <= (dmem_we || dmem_re) && fault;
            if (dmem_re) begin
                if (fault)
                    dmem_rdata <= 32'h0;
                else if (ram_hit)
                    dmem_rdata <= mem[idx];
                else
                    dmem_rdata <= mmio_rdata;
            end
        end
    end

    dmem_mmio u_mmio (
        .clk    (clk),
        .rst    (rst),
        .led_we (wr_ok && led_hit),
        .wdata  (dmem_wdata),
        .rd_cyc (cyc_hit),
        .led_o  (led_o),
        .rdata  (mmio_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, faults, MMIO registers, reset behaviour.
module tb_dmem_responder;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_we;
    logic        dmem_re;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [1:0]  dmem_size;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        dmem_err;
    logic [31:0] led_o;

    int n_chk = 0;
    int n_bad = 0;
    logic [31:0] c0;
    logic [31:0] c1;

    dmem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .dmem_we     (dmem_we),
        .dmem_re     (dmem_re),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_size   (dmem_size),
        .dmem_rdata  (dmem_rdata),
        .dmem_rvalid (dmem_rvalid),
        .dmem_err    (dmem_err),
        .led_o       (led_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Presents one request for one cycle; returns #1 after the capturing edge.
    task automatic req(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz);
        dmem_we    = we;
        dmem_re    = re;
        dmem_addr  = a;
        dmem_wdata = d;
        dmem_size  = sz;
        @(posedge clk);
        #1;
        dmem_we = 1'b0;
        dmem_re = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        req(1'b1, 1'b0, a, d, sz);
    endtask

    task automatic ld(input logic [31:0] a);
        req(1'b0, 1'b1, a, 32'h0, 2'd2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; dmem_we = 1'b0; dmem_re = 1'b0;
        dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_size = 2'd2;
        idle(2);
        chk("rst_rdata", dmem_rdata, 32'h0);
        chk("rst_rvalid", {31'h0, dmem_rvalid}, 32'h0);
        chk("rst_err", {31'h0, dmem_err}, 32'h0);
        chk("rst_led", led_o, 32'h0);
        rst = 1'b1;

        st(32'h10, 32'hDEAD_BEEF, 2'd2);
        chk("st_rvalid", {31'h0, dmem_rvalid}, 32'h0);
        chk("st_err", {31'h0, dmem_err}, 32'h0);
        ld(32'h10);
        chk("ld10_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("ld10_rdata", dmem_rdata, 32'hDEAD_BEEF);

        st(32'h20, 32'h1122_3344, 2'd2);
        st(32'h22, 32'h0000_00AA, 2'd0);
        ld(32'h20);
        chk("byte_lane", dmem_rdata, 32'h11AA_3344);
        st(32'h20, 32'h0000_5566, 2'd1);
        ld(32'h20);
        chk("half_lane", dmem_rdata, 32'h11AA_5566);
        st(32'h27, 32'h0000_0077, 2'd0);
        ld(32'h24);
        chk("byte_lane3", dmem_rdata & 32'hFF00_0000, 32'h7700_0000);

        ld(32'h10);
        chk("b2b0_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("b2b0_rdata", dmem_rdata, 32'hDEAD_BEEF);
        ld(32'h20);
        chk("b2b1_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("b2b1_rdata", dmem_rdata, 32'h11AA_5566);
        idle(1);
        chk("idle_rvalid", {31'h0, dmem_rvalid}, 32'h0);
        chk("idle_err", {31'h0, dmem_err}, 32'h0);
        chk("idle_hold", dmem_rdata, 32'h11AA_5566);

        req(1'b0, 1'b1, 32'h21, 32'h0, 2'd1);
        chk("half_mis_err", {31'h0, dmem_err}, 32'h1);
        chk("half_mis_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("half_mis_rdata", dmem_rdata, 32'h0);
        st(32'h22, 32'hFFFF_FFFF, 2'd2);
        chk("word_mis_err", {31'h0, dmem_err}, 32'h1);
        chk("word_mis_rvalid", {31'h0, dmem_rvalid}, 32'h0);
        req(1'b1, 1'b0, 32'h20, 32'hFFFF_FFFF, 2'd3);
        chk("sz3_st_err", {31'h0, dmem_err}, 32'h1);
        req(1'b0, 1'b1, 32'h20, 32'h0, 2'd3);
        chk("sz3_ld_err", {31'h0, dmem_err}, 32'h1);
        chk("sz3_ld_rdata", dmem_rdata, 32'h0);
        req(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 2'd2);
        chk("werd_err", {31'h0, dmem_err}, 32'h1);
        chk("werd_rvalid", {31'h0, dmem_rvalid}, 32'h1);
        chk("werd_rdata", dmem_rdata, 32'h0);
        ld(32'h8000_0000);
        chk("unmapped_err", {31'h0, dmem_err}, 32'h1);
        ld(32'h20);
        chk("fault_no_write", dmem_rdata, 32'h11AA_5566);
        chk("good_ld_err", {31'h0, dmem_err}, 32'h0);

        st(MB, 32'h0000_00FF, 2'd2);
        chk("led_st", led_o, 32'h0000_00FF);
        chk("led_st_err", {31'h0, dmem_err}, 32'h0);
        st(MB, 32'h0000_0012, 2'd0);
        chk("led_byte_err", {31'h0, dmem_err}, 32'h1);
        chk("led_byte_keep", led_o, 32'h0000_00FF);
        ld(MB);
        chk("led_ld", dmem_rdata, 32'h0000_00FF);

        ld(MB + 32'h4);
        c0 = dmem_rdata;
        st(MB + 32'h4, 32'h0, 2'd2);
        chk("cyc_st_err", {31'h0, dmem_err}, 32'h0);
        idle(3);
        ld(MB + 32'h4);
        c1 = dmem_rdata;
        chk("cyc_delta5", c1 - c0, 32'h5);

        dmem_re = 1'b1; dmem_addr = 32'h10; dmem_size = 2'd2;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem_we = 1'b1; dmem_addr = MB; dmem_wdata = 32'h0000_0055;
        dmem_re = 1'b0;
        @(posedge clk);
        #1;
        dmem_we = 1'b0;
        chk("rstx_rvalid", {31'h0, dmem_rvalid}, 32'h0);
        chk("rstx_led", led_o, 32'h0);
        chk("rstx_rdata", dmem_rdata, 32'h0);
        rst = 1'b1;
        ld(MB + 32'h4);
        chk("rstx_cyc0", dmem_rdata, 32'h0);
        ld(32'h10);
        chk("rstx_ram_keep", dmem_rdata, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: RAM depth in 32-bit words (power of two).
REQ-002 Parameter MMIO_BASE, default 32'h1000_0000: base address of the MMIO register window.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous active-low reset; rst=0 sampled at posedge resets the block.
REQ-005 dmem_we  input  1  store request this cycle.
REQ-006 dmem_re  input  1  load request this cycle.
REQ-007 dmem_addr  input  32  byte address of the request.
REQ-008 dmem_wdata  input  32  store data; the low byte/half/word is used per dmem_size.
REQ-009 dmem_size  input  2  access size: 0=byte, 1=half, 2=word; 3 is illegal.
REQ-010 dmem_rdata  output  32  registered load data, aligned 32-bit word.
REQ-011 dmem_rvalid  output  1  one-cycle pulse; dmem_rdata is valid this cycle.
REQ-012 dmem_err  output  1  one-cycle pulse flagging a faulted request from the previous cycle.
REQ-013 led_o  output  32  current value of the MMIO LED register.

Function
REQ-014 RAM region: word index dmem_addr[log2(DEPTH_WORDS)+1:2]; hit when dmem_addr < DEPTH_WORDS*4.
REQ-015 MMIO region: MMIO_BASE+0 = LED register (R/W, word only); MMIO_BASE+4 = CYCLE counter (read-only).
REQ-016 Store byte lanes: byte -> lane dmem_addr[1:0] gets wdata[7:0]; half -> lanes {a1,a1+1} (a1 = dmem_addr[1]*2) get wdata[15:0]; word -> all lanes.
REQ-017 Store commits at the posedge where dmem_we=1; unselected lanes are unchanged.
REQ-018 Load latency is exactly 1 cycle: re=1 at cycle N -> rvalid=1 and rdata=word at cycle N+1.
REQ-019 Load following a store to the same word in the previous cycle returns the updated word.
REQ-020 Fault conditions: half with addr[0]=1; word with addr[1:0]!=0; size=3; address in neither region; MMIO access not word-sized; we and re both 1.
REQ-021 On fault: no state change; err=1 at N+1; if re was 1, rvalid=1 and rdata=0 at N+1.
REQ-022 Store to CYCLE is ignored without err; load of CYCLE returns the counter value at cycle N.
REQ-023 CYCLE increments by 1 every cycle out of reset and wraps 32'hFFFF_FFFF -> 0.
REQ-024 When we=0 and re=0: rvalid=0, err=0, and rdata holds its last value.
REQ-025 Back-to-back loads on consecutive cycles produce rvalid on consecutive cycles; no stalls.

Reset
REQ-026 rst=0: rdata=0, rvalid=0, err=0, led_o=0, CYCLE=0 at the next posedge.
REQ-027 RAM contents are not reset.
REQ-028 A load issued in the cycle before or the cycle of reset produces no rvalid after reset.
REQ-029 Requests presented while rst=0 are ignored.

Structure
REQ-030 Package dmem_pkg holds the size encodings (SZ_B, SZ_H, SZ_W), MMIO offsets (LED_OFS=0, CYC_OFS=4), and the byte-lane function.
REQ-031 Sub-module dmem_mmio holds the LED register, the CYCLE counter, and MMIO read muxing; RAM and decode stay in dmem_responder.

Verification
REQ-032 Store word 32'hDEADBEEF @0x10, then load 0x10 -> rvalid next cycle, rdata=32'hDEADBEEF.
REQ-033 Word @0x20 = 32'h11223344, then byte store 8'hAA @0x22 -> load 0x20 returns 32'h11AA3344; half store 16'h5566 @0x20 -> 32'h11AA5566.
REQ-034 Half load @0x21, word store @0x22, size=3, and we=re=1 -> each err=1 one cycle later; RAM unchanged; load variants return rdata=0 with rvalid=1.
REQ-035 Word store 32'h0000_00FF @MMIO_BASE -> led_o=32'hFF next cycle; byte store @MMIO_BASE -> err, led_o unchanged.
REQ-036 Two loads of MMIO_BASE+4 five cycles apart -> returned values differ by 5; store to MMIO_BASE+4 -> no err, counter unaffected.
REQ-037 Issue a load, drive rst=0 the next cycle -> rvalid=0, led_o=0, CYCLE=0 after reset; RAM word written before reset still reads back.
